// File: rtl/mips_seq_alu.sv
// mips_seq_alu: registered MIPS ALU with a valid/ready issue port and an
// iterative multiply/divide unit that owns the architectural HI/LO registers.
//
// Handshake: an operation is accepted on a rising CLK edge where
// in_valid && in_ready; in_ready is high only while the FSM is in IDLE, and
// in_valid is ignored otherwise (nothing is queued). out_valid is a single-cycle
// pulse marking the cycle in which ALUOut/Zero/Overflow/DivZero/HI/LO are final.
module mips_seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    // Multiply: r_acc = {partial high, multiplier shifting out}.
    // Divide:   r_acc = {partial remainder, dividend shifting into quotient}.
    // Divide by zero: r_acc = {A, all ones}, copied straight to HI/LO at FIX.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;      // |multiplicand| or |divisor|
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_mul;
    logic               r_dz;
    logic               r_neg_q;    // product/quotient must be negated
    logic               r_neg_r;    // remainder must be negated (A was negative)

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_b_zero;
    logic               w_signed_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_simple_res;
    logic               w_simple_ovf;
    logic               w_last;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_quot_neg;
    logic [WIDTH-1:0]   w_rem_neg;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_is_mul    = (ALUCtl == OP_MULT) || (ALUCtl == OP_MULTU);
    assign w_is_div    = (ALUCtl == OP_DIV)  || (ALUCtl == OP_DIVU);
    assign w_b_zero    = (B == '0);
    assign w_signed_op = (ALUCtl == OP_MULT) || (ALUCtl == OP_DIV);
    assign w_a_neg     = w_signed_op & A[WIDTH-1];
    assign w_b_neg     = w_signed_op & B[WIDTH-1];
    assign w_abs_a     = w_a_neg ? (~A + 1'b1) : A;
    assign w_abs_b     = w_b_neg ? (~B + 1'b1) : B;
    assign w_sum       = A + B;
    assign w_diff      = A - B;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // One shift-add step: conditionally add the multiplicand to the high half,
    // then shift the whole accumulator right, keeping the carry.
    assign w_addend    = r_acc[0] ? r_opb : '0;
    assign w_mul_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next  = {w_mul_add, r_acc[WIDTH-1:1]};

    // One restoring-division step: shift the next dividend bit into the
    // remainder and keep the subtraction only when it does not borrow.
    assign w_trial     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
    assign w_div_next  = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                        : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_neg  = ~r_acc + 1'b1;
    assign w_quot_neg  = ~r_acc[WIDTH-1:0] + 1'b1;
    assign w_rem_neg   = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;

    assign in_ready    = (r_state == S_IDLE);
    assign dbg_state   = r_state;

    // Single-cycle result and ADD/SUB signed overflow for the simple ops.
    always_comb begin
        w_simple_res = '0;
        w_simple_ovf = 1'b0;
        case (ALUCtl)
            OP_AND:  w_simple_res = A & B;
            OP_OR:   w_simple_res = A | B;
            OP_XOR:  w_simple_res = A ^ B;
            OP_NOR:  w_simple_res = ~(A | B);
            OP_ADD: begin
                w_simple_res = w_sum;
                w_simple_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_simple_res = w_diff;
                w_simple_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLTU: w_simple_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:  w_simple_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_MFHI: w_simple_res = HI;
            OP_MFLO: w_simple_res = LO;
            default: w_simple_res = '0;
        endcase
    end

    // Sign correction of the finished magnitude result, applied in FIX.
    always_comb begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
        if (r_is_mul) begin
            if (r_neg_q) begin
                w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
                w_fix_lo = w_prod_neg[WIDTH-1:0];
            end
        end else if (!r_dz) begin
            if (r_neg_q) w_fix_lo = w_quot_neg;
            if (r_neg_r) w_fix_hi = w_rem_neg;
        end
    end

    // Next-state logic for the multiply/divide sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (w_is_mul)      w_state_nx = S_MUL;
                    else if (w_is_div) w_state_nx = w_b_zero ? S_FIX : S_DIV;
                end
            end
            S_MUL:   if (w_last) w_state_nx = S_FIX;
            S_DIV:   if (w_last) w_state_nx = S_FIX;
            S_FIX:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    // Operand latching, iteration datapath, HI/LO and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_acc     <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_dz      <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            out_valid <= 1'b0;
            ALUOut    <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivZero   <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul || w_is_div) begin
                            r_cnt    <= '0;
                            r_is_mul <= w_is_mul;
                            r_dz     <= w_is_div && w_b_zero;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_opb    <= w_abs_b;
                            if (w_is_div && w_b_zero) r_acc <= {A, {WIDTH{1'b1}}};
                            else                      r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                        end else begin
                            ALUOut    <= w_simple_res;
                            Zero      <= (w_simple_res == '0);
                            Overflow  <= w_simple_ovf;
                            DivZero   <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    HI        <= w_fix_hi;
                    LO        <= w_fix_lo;
                    ALUOut    <= w_fix_lo;
                    Zero      <= (w_fix_lo == '0);
                    Overflow  <= 1'b0;
                    DivZero   <= r_dz;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_seq_alu.sv
// tb_mips_seq_alu: vector table for simple ops, hand sequences for the
// multi-cycle corners, then random ops checked against an arithmetic model.
`timescale 1ns/1ps
module tb_mips_seq_alu;

    localparam int W = 32;
    localparam longint MAXS = 64'sh7FFFFFFF;
    localparam longint MINS = -64'sh80000000;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [3:0]   ALUCtl;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] ALUOut;
    logic         Zero;
    logic         Overflow;
    logic         DivZero;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    typedef struct {
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t tbl[16];

    mips_seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK(CLK), .RESET(RESET), .ALUCtl(ALUCtl), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero),
        .HI(HI), .LO(LO), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 CLK = ~CLK;

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: results straight from signed/unsigned integer math.
    task automatic model_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] res, output logic ovf, output logic dz,
                            output int lat);
        longint sa, sb, s, q, r;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0; ovf = 1'b0; dz = 1'b0; lat = 1;
        case (c)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2:  begin s = sa + sb; res = a + b; ovf = (s > MAXS) || (s < MINS); end
            4'd3:  res = a ^ b;
            4'd4:  res = (a < b) ? 1 : 0;
            4'd6:  begin s = sa - sb; res = a - b; ovf = (s > MAXS) || (s < MINS); end
            4'd7:  res = (sa < sb) ? 1 : 0;
            4'd12: res = ~(a | b);
            4'd13: res = m_hi;
            4'd14: res = m_lo;
            4'd8:  begin s = sa * sb; m_hi = s[63:32]; m_lo = s[31:0]; res = m_lo; lat = W + 2; end
            4'd9:  begin up = {32'h0, a} * {32'h0, b}; m_hi = up[63:32]; m_lo = up[31:0]; res = m_lo; lat = W + 2; end
            4'd10, 4'd11: begin
                if (b == 0) begin
                    m_hi = a; m_lo = '1; dz = 1'b1; lat = 2;
                end else if (c == 4'd10) begin
                    q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; lat = W + 2;
                end else begin
                    m_lo = a / b; m_hi = a % b; lat = W + 2;
                end
                res = m_lo;
            end
            default: res = '0;
        endcase
    endtask

    // Driver: wait (bounded) for in_ready, then present the op for one edge.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!in_ready) chk("issue_ready_timeout", 0, 1);
        ALUCtl = c; A = a; B = b; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    // Latency counted so that a result visible right after the accept edge is 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        logic [W-1:0] eres, got_exp;
        logic eovf, edz;
        int elat;
        model_op(c, a, b, eres, eovf, edz, elat);
        exp_q.push_back(eres);
        issue(c, a, b);
        wait_done(lat);
        got_exp = exp_q.pop_front();
        chk($sformatf("op%0d_latency", c), 64'(lat), 64'(elat));
        chk($sformatf("op%0d_aluout", c), ALUOut, got_exp);
        chk($sformatf("op%0d_zero", c), Zero, (got_exp == 0));
        chk($sformatf("op%0d_overflow", c), Overflow, eovf);
        chk($sformatf("op%0d_divzero", c), DivZero, edz);
        chk($sformatf("op%0d_hi", c), HI, m_hi);
        chk($sformatf("op%0d_lo", c), LO, m_lo);
        @(posedge CLK); #1;
        chk($sformatf("op%0d_pulse_end", c), out_valid, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return '1;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        int lat, lowcnt, seen;
        logic [3:0] c;

        tbl[0]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        tbl[1]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tbl[2]  = '{4'd2,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        tbl[3]  = '{4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        tbl[4]  = '{4'd6,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        tbl[5]  = '{4'd6,  32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1};
        tbl[6]  = '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        tbl[7]  = '{4'd1,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[8]  = '{4'd3,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0};
        tbl[9]  = '{4'd12, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[10] = '{4'd12, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};
        tbl[11] = '{4'd4,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
        tbl[12] = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        tbl[13] = '{4'd7,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        tbl[14] = '{4'd5,  32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0};
        tbl[15] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};

        // Reset.
        RESET = 1'b1; ALUCtl = '0; A = '0; B = '0; in_valid = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("reset_aluout", ALUOut, 0);
        chk("reset_zero", Zero, 0);
        chk("reset_overflow", Overflow, 0);
        chk("reset_divzero", DivZero, 0);
        chk("reset_hi", HI, 0);
        chk("reset_lo", LO, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);

        // Simple-op vector table, issued on consecutive cycles.
        for (int i = 0; i < 16; i++) begin
            issue(tbl[i].ctl, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_aluout", i), ALUOut, tbl[i].res);
            chk($sformatf("tbl%0d_zero", i), Zero, tbl[i].zero);
            chk($sformatf("tbl%0d_overflow", i), Overflow, tbl[i].ovf);
            chk($sformatf("tbl%0d_divzero", i), DivZero, 0);
            chk($sformatf("tbl%0d_hi", i), HI, 0);
            chk($sformatf("tbl%0d_lo", i), LO, 0);
        end
        @(posedge CLK); #1;
        chk("tbl_pulse_end", out_valid, 0);

        // SLT then SLTU back-to-back with in_valid held.
        ALUCtl = 4'd7; A = 32'hFFFFFFFF; B = 32'h1; in_valid = 1'b1;
        @(posedge CLK); #1;
        chk("slt_b2b_valid", out_valid, 1);
        chk("slt_b2b_result", ALUOut, 1);
        chk("slt_b2b_ready", in_ready, 1);
        ALUCtl = 4'd4;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("sltu_b2b_valid", out_valid, 1);
        chk("sltu_b2b_result", ALUOut, 0);
        chk("sltu_b2b_ready", in_ready, 1);

        // MULT -3 * 5, then MFLO.
        run_op(4'd8, 32'hFFFFFFFD, 32'h5, lat);
        chk("mult_latency_34", 64'(lat), 34);
        chk("mult_hi_const", HI, 32'hFFFFFFFF);
        chk("mult_lo_const", LO, 32'hFFFFFFF1);
        run_op(4'd14, 32'h0, 32'h0, lat);
        chk("mflo_const", ALUOut, 32'hFFFFFFF1);

        // DIV -7 / 2, then DIVU 7 / 0.
        run_op(4'd10, 32'hFFFFFFF9, 32'h2, lat);
        chk("div_lo_const", LO, 32'hFFFFFFFD);
        chk("div_hi_const", HI, 32'hFFFFFFFF);
        run_op(4'd11, 32'h7, 32'h0, lat);
        chk("divz_latency_2", 64'(lat), 2);
        chk("divz_hi_const", HI, 32'h7);
        chk("divz_lo_const", LO, 32'hFFFFFFFF);
        chk("divz_flag_const", DivZero, 1);

        // Signed min / -1.
        run_op(4'd10, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("minneg1_lo", LO, 32'h80000000);
        chk("minneg1_hi", HI, 32'h0);
        chk("minneg1_divzero", DivZero, 0);

        // MULTU with an ADD held on the port for the whole operation.
        issue(4'd9, 32'h12345678, 32'h9ABCDEF0);
        begin
            logic [W-1:0] r0; logic o0, d0; int l0;
            model_op(4'd9, 32'h12345678, 32'h9ABCDEF0, r0, o0, d0, l0);
        end
        ALUCtl = 4'd2; A = 32'd100; B = 32'd23; in_valid = 1'b1;
        lowcnt = 0;
        while (!in_ready && lowcnt < 200) begin
            lowcnt++;
            @(posedge CLK); #1;
        end
        // in_ready comes back in the same cycle as the out_valid pulse,
        // i.e. W+2 cycles after the accept cycle.
        chk("multu_ready_low_cycles", 64'(lowcnt), W + 1);
        chk("multu_done_valid", out_valid, 1);
        chk("multu_hi", HI, m_hi);
        chk("multu_lo", LO, m_lo);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("held_add_valid", out_valid, 1);
        chk("held_add_result", ALUOut, 32'd123);
        chk("held_add_hi", HI, m_hi);
        chk("held_add_lo", LO, m_lo);

        // Reset pulsed 10 cycles into a MULT.
        issue(4'd8, 32'hFFFFFFFD, 32'h5);
        repeat (10) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("midreset_aluout", ALUOut, 0);
        chk("midreset_hi", HI, 0);
        chk("midreset_lo", LO, 0);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        m_hi = '0; m_lo = '0;
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge CLK); #1;
            if (out_valid) seen++;
        end
        chk("midreset_no_out_valid", 64'(seen), 0);
        chk("midreset_ready_after", in_ready, 1);
        run_op(4'd13, 32'h0, 32'h0, lat);
        chk("mfhi_after_reset", ALUOut, 0);

        // Random mix against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) c = 4'($urandom_range(8, 11));
            else                           c = 4'($urandom_range(0, 15));
            run_op(c, pick(), pick(), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
